// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM state encoding and the iteration counter width helper.
package seq_div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } div_state_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_signed_divider_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor magnitude, restore on borrow.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   prem,
  input  logic         din,
  input  logic [N-1:0] dsr,
  output logic [N:0]   rem_nxt,
  output logic         qbit
);

  logic [N+1:0] sh;
  logic [N+1:0] diff;

  // shift, trial-subtract, and keep or restore
  always_comb begin
    sh      = {prem, din};
    diff    = sh - {2'b00, dsr};
    qbit    = ~diff[N+1];
    rem_nxt = diff[N+1] ? sh[N:0] : diff[N:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 2N/N restoring division on magnitudes,
// one quotient bit per clock, sign fix-up, START/DONE handshake.
module seq_signed_divider
  import seq_div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic [2*N-1:0] DIVIDEND,
  input  logic [N-1:0]   DIVISOR,
  output logic [N-1:0]   QUOT,
  output logic [N-1:0]   REM,
  output logic           BUSY,
  output logic           DONE,
  output logic           DIV0,
  output logic           OVF
);

  localparam int CW = cnt_w(N);

  div_state_t     state;
  logic [2*N-1:0] dd_q;
  logic [N-1:0]   ds_q;
  logic           sgn_q;
  logic           sgn_r;
  logic [N:0]     prem;
  logic [N-1:0]   sreg;
  logic [CW-1:0]  cnt;

  logic [2*N-1:0] add;
  logic [N-1:0]   ads;
  logic           q_ovf;
  logic [N:0]     step_rem;
  logic           step_q;

  // operand magnitudes and the final-range test on the quotient
  always_comb begin
    add   = dd_q[2*N-1] ? -dd_q : dd_q;
    ads   = ds_q[N-1] ? -ds_q : ds_q;
    q_ovf = sgn_q ? (sreg[N-1] & (|sreg[N-2:0]))
                  : sreg[N-1];
  end

  div_step #(.N(N)) u_step (
    .prem    (prem),
    .din     (sreg[N-1]),
    .dsr     (ds_q),
    .rem_nxt (step_rem),
    .qbit    (step_q)
  );

  // control FSM, datapath registers and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      dd_q  <= '0;
      ds_q  <= '0;
      sgn_q <= 1'b0;
      sgn_r <= 1'b0;
      prem  <= '0;
      sreg  <= '0;
      cnt   <= '0;
      QUOT  <= '0;
      REM   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      DIV0  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            dd_q  <= DIVIDEND;
            ds_q  <= DIVISOR;
            sgn_q <= DIVIDEND[2*N-1] ^ DIVISOR[N-1];
            sgn_r <= DIVIDEND[2*N-1];
            BUSY  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          ds_q <= ads;
          cnt  <= '0;
          if (ads == '0) begin
            DIV0  <= 1'b1;
            OVF   <= 1'b0;
            QUOT  <= '0;
            REM   <= '0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else if (add[2*N-1:N] >= ads) begin
            DIV0  <= 1'b0;
            OVF   <= 1'b1;
            QUOT  <= '0;
            REM   <= '0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            prem  <= {1'b0, add[2*N-1:N]};
            sreg  <= add[N-1:0];
            state <= S_ITER;
          end
        end
        S_ITER: begin
          prem <= step_rem;
          sreg <= {sreg[N-2:0], step_q};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N-1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          DIV0 <= 1'b0;
          if (q_ovf) begin
            OVF  <= 1'b1;
            QUOT <= '0;
            REM  <= '0;
          end else begin
            OVF  <= 1'b0;
            QUOT <= sgn_q ? -sreg : sreg;
            REM  <= sgn_r ? -prem[N-1:0] : prem[N-1:0];
          end
          DONE  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
